// File: rtl/mc_dp_pack.sv
// mc_dp_pack: packs narrow memory-controller read beats (8-bit, 16-bit or full
// DW-bit bus) into DW-bit words and queues them in a small first-word-fall-through
// FIFO with occupancy, sticky overflow and head-of-queue parity reporting.
// Optional build macro MC_DP_PARITY_EN: keep the per-byte parity bits with each
// FIFO entry and flag even-parity errors on the head word. Without it only data
// is stored and par_err is held low.
module mc_dp_pack #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [1:0]           bus_width,
    input  logic                 pen,
    input  logic                 dv,
    input  logic [DW+DW/8-1:0]   mc_data_del,
    input  logic                 re,
    input  logic [DW/8-1:0]      byte_en,
    output logic [DW-1:0]        dout,
    output logic                 empty,
    output logic                 full,
    output logic [AW:0]          cnt,
    output logic                 ovf,
    output logic                 par_err
);

    localparam int NB = DW / 8;
    localparam int NH = DW / 16;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;
`ifdef MC_DP_PARITY_EN
    localparam int EW = DW + NB;
`else
    localparam int EW = DW;
`endif

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [LW-1:0] lane_reg;
    logic [LW-1:0] lane_next;
    logic [LW-1:0] last_lane;
    logic          word_done;
    logic [EW-1:0] word_entry;

    // Index of the beat that completes a word for the current bus width.
    always_comb begin
        last_lane = '0;
        case (bus_width)
            2'b00:   last_lane = LW'(NB - 1);
            2'b01:   last_lane = LW'(NH - 1);
            default: last_lane = '0;
        endcase
    end

    assign word_done = dv & (lane_reg == last_lane);

    // Lane counter moves only on valid beats and wraps on the completing beat.
    always_comb begin
        lane_next = lane_reg;
        if (dv) begin
            lane_next = word_done ? '0 : lane_reg + LW'(1);
        end
    end

    // Lane counter register; flush and reset both restart packing at lane 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_reg <= '0;
        end else if (clr) begin
            lane_reg <= '0;
        end else begin
            lane_reg <= lane_next;
        end
    end

    // One slice per output byte: decide whether the current beat lands here,
    // which beat byte feeds it, and hold it until the word completes. The word
    // pushed on the completing beat takes that beat's bytes straight from the
    // input so the push happens on the same edge.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            logic       hit;
            logic [7:0] src;
            logic [7:0] byte_reg;

            // Lane-to-byte routing for the three bus widths.
            always_comb begin
                hit = 1'b0;
                src = mc_data_del[gi*8 +: 8];
                case (bus_width)
                    2'b00: begin
                        hit = (lane_reg == LW'(gi));
                        src = mc_data_del[7:0];
                    end
                    2'b01: begin
                        hit = (lane_reg == LW'(gi / 2));
                        src = mc_data_del[(gi % 2)*8 +: 8];
                    end
                    default: begin
                        hit = 1'b1;
                        src = mc_data_del[gi*8 +: 8];
                    end
                endcase
            end

            // Byte holding register, deliberately not reset.
            always_ff @(posedge clk) begin
                if (dv && hit && !clr) begin
                    byte_reg <= src;
                end
            end

            assign word_entry[gi*8 +: 8] = (dv && hit) ? src : byte_reg;

`ifdef MC_DP_PARITY_EN
            logic psrc;
            logic par_reg;

            // Parity bit follows its data byte through the same routing.
            always_comb begin
                case (bus_width)
                    2'b00:   psrc = mc_data_del[DW];
                    2'b01:   psrc = mc_data_del[DW + (gi % 2)];
                    default: psrc = mc_data_del[DW + gi];
                endcase
            end

            // Parity holding bit, deliberately not reset.
            always_ff @(posedge clk) begin
                if (dv && hit && !clr) begin
                    par_reg <= psrc;
                end
            end

            assign word_entry[DW + gi] = (dv && hit) ? psrc : par_reg;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   cnt_reg;
    logic [AW:0]   cnt_next;
    logic          ovf_reg;
    logic          ovf_next;
    logic          pop;
    logic          wr_en;
    logic [EW-1:0] head_entry;

    assign empty = (cnt_reg == '0);
    assign full  = (cnt_reg == (AW+1)'(DEPTH));
    assign cnt   = cnt_reg;
    assign ovf   = ovf_reg;

    // A pop while empty is ignored; a push while full only lands if a pop
    // frees the slot in the same cycle.
    assign pop   = re & ~empty;
    assign wr_en = word_done & (~full | pop);

    // Pointer, occupancy and sticky-overflow next state.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        ovf_next    = ovf_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (wr_en && !pop) begin
            cnt_next = cnt_reg + (AW+1)'(1);
        end else if (pop && !wr_en) begin
            cnt_next = cnt_reg - (AW+1)'(1);
        end
        if (word_done && full && !pop) begin
            ovf_next = 1'b1;
        end
    end

    // FIFO control registers; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Storage write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr_reg] <= word_entry;
        end
    end

    // Fall-through read: the head entry is visible without a pop.
    assign head_entry = mem[rd_ptr_reg];
    assign dout       = head_entry[DW-1:0];

`ifdef MC_DP_PARITY_EN
    logic [NB-1:0] lane_bad;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_par
            assign lane_bad[gi] = byte_en[gi] &
                                  ((^head_entry[gi*8 +: 8]) ^ head_entry[DW + gi]);
        end
    endgenerate

    assign par_err = pen & ~empty & (|lane_bad);
`else
    // Parity inputs have no function in this build.
    logic unused_par;
    assign unused_par = ^{pen, byte_en, mc_data_del[DW +: NB]};
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_dp_pack.sv
// Self-checking bench for mc_dp_pack (DW=32, DEPTH=4). Expected FIFO words are
// queued when the completing beat is driven and compared against the head.
module tb_mc_dp_pack;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [1:0]  bus_width;
    logic        pen;
    logic        dv;
    logic [35:0] mc_data_del;
    logic        re;
    logic [3:0]  byte_en;
    logic [31:0] dout;
    logic        empty;
    logic        full;
    logic [2:0]  cnt;
    logic        ovf;
    logic        par_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    mc_dp_pack #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .bus_width   (bus_width),
        .pen         (pen),
        .dv          (dv),
        .mc_data_del (mc_data_del),
        .re          (re),
        .byte_en     (byte_en),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .cnt         (cnt),
        .ovf         (ovf),
        .par_err     (par_err)
    );

    // Build one beat of word w for the given bus width; unused upper lanes
    // carry random junk and parity bits are even parity of their byte.
    function automatic logic [35:0] make_beat(input logic [1:0] bw, input logic [31:0] w, input int idx);
        logic [35:0] b;
        b = {4'($urandom), 32'($urandom)};
        case (bw)
            2'b00: begin
                b[7:0] = w[idx*8 +: 8];
                b[32]  = ^w[idx*8 +: 8];
            end
            2'b01: begin
                b[15:0] = w[idx*16 +: 16];
                b[32]   = ^w[idx*16 +: 8];
                b[33]   = ^w[idx*16+8 +: 8];
            end
            default: begin
                b[31:0] = w;
                for (int k = 0; k < 4; k++) b[32+k] = ^w[k*8 +: 8];
            end
        endcase
        return b;
    endfunction

    // Drive one clock of stimulus and advance the reference queue.
    task automatic cycle(input logic dv_i, input logic [35:0] beat, input logic re_i,
                         input logic clr_i, input logic done_i, input logic [31:0] word_i);
        bit pop_ok;
        bit push_ok;
        dv          = dv_i;
        mc_data_del = beat;
        re          = re_i;
        clr         = clr_i;
        pop_ok  = re_i && (exp_q.size() > 0);
        push_ok = done_i && ((exp_q.size() < DEPTH) || pop_ok);
        @(posedge clk);
        #1;
        if (clr_i) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            $display("[%0t] clr", $time);
        end else begin
            if (pop_ok) $display("[%0t] pop  %h", $time, exp_q.pop_front());
            if (push_ok) begin
                exp_q.push_back(word_i);
                $display("[%0t] push %h", $time, word_i);
            end else if (done_i) begin
                exp_ovf = 1'b1;
                $display("[%0t] drop %h (full)", $time, word_i);
            end
        end
        dv  = 1'b0;
        re  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] bw, input logic [31:0] w);
        int nb;
        nb = (bw == 2'b00) ? 4 : (bw == 2'b01) ? 2 : 1;
        bus_width = bw;
        for (int i = 0; i < nb; i++) cycle(1'b1, make_beat(bw, w, i), 1'b0, 1'b0, i == nb - 1, w);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (cnt !== 3'd0)     begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pack8();
        bus_width = 2'b00;
        cycle(1'b1, 36'h0_0000_0011, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'h0_0000_0022, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'h0_0000_0033, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'h0_0000_0044, 1'b0, 1'b0, 1'b1, 32'h4433_2211);
        checks++; if (empty !== 1'b0)       begin errors++; $display("FAIL pack8_empty: got %b expected 0", empty); end
        checks++; if (dout !== 32'h44332211) begin errors++; $display("FAIL pack8_dout: got %h expected 44332211", dout); end
        checks++; if (cnt !== 3'd1)         begin errors++; $display("FAIL pack8_cnt: got %0d expected 1", cnt); end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL pack8_pop_empty: got %b expected 1", empty); end
    endtask

    task automatic test_pack16();
        bus_width = 2'b01;
        cycle(1'b1, 36'hF_1234_BEEF, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'hA_5678_DEAD, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL pack16_dout: got %h expected deadbeef", dout); end
        checks++; if (empty !== 1'b0)        begin errors++; $display("FAIL pack16_empty: got %b expected 0", empty); end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL pack16_pop_empty: got %b expected 1", empty); end
        checks++; if (cnt !== 3'd0)          begin errors++; $display("FAIL pack16_pop_cnt: got %0d expected 0", cnt); end
        // re while empty must leave everything alone
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        checks++; if (cnt !== 3'd0)          begin errors++; $display("FAIL empty_pop_cnt: got %0d expected 0", cnt); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) send_word(2'b10, 32'hA000_0000 + 32'(i));
        checks++; if (full !== 1'b1)         begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (cnt !== 3'd4)          begin errors++; $display("FAIL ovf_cnt: got %0d expected 4", cnt); end
        checks++; if (ovf !== 1'b1)          begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        checks++; if (dout !== 32'hA0000001) begin errors++; $display("FAIL ovf_head: got %h expected a0000001", dout); end
        cycle(1'b1, make_beat(2'b10, 32'hA000_0006, 0), 1'b1, 1'b0, 1'b1, 32'hA000_0006);
        checks++; if (cnt !== 3'd4)          begin errors++; $display("FAIL pushpop_full_cnt: got %0d expected 4", cnt); end
        checks++; if (dout !== 32'hA0000002) begin errors++; $display("FAIL pushpop_full_head: got %h expected a0000002", dout); end
        checks++; if (full !== 1'b1)         begin errors++; $display("FAIL pushpop_full_flag: got %b expected 1", full); end
        checks++; if (ovf !== exp_ovf)       begin errors++; $display("FAIL pushpop_ovf: got %b expected %b", ovf, exp_ovf); end
    endtask

    task automatic test_clr();
        bus_width = 2'b00;
        cycle(1'b1, 36'h0_0000_00EE, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'h0_0000_00DD, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'h0_0000_00CC, 1'b1, 1'b1, 1'b0, '0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b expected 1", empty); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
        checks++; if (cnt !== 3'd0)   begin errors++; $display("FAIL clr_cnt: got %0d expected 0", cnt); end
        send_word(2'b00, 32'h5A6B_7C8D);
        checks++; if (dout !== 32'h5A6B7C8D) begin errors++; $display("FAIL clr_next_word: got %h expected 5a6b7c8d", dout); end
        checks++; if (cnt !== 3'd1)          begin errors++; $display("FAIL clr_next_cnt: got %0d expected 1", cnt); end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_parity();
        logic exp_bad;
`ifdef MC_DP_PARITY_EN
        exp_bad = 1'b1;
`else
        exp_bad = 1'b0;
`endif
        bus_width = 2'b10;
        // byte1 = 0x01 carries parity bit 0: odd overall, so a parity fault
        cycle(1'b1, 36'h0_0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        pen = 1'b1; byte_en = 4'b0010; #1;
        checks++; if (par_err !== exp_bad) begin errors++; $display("FAIL par_lane1: got %b expected %b", par_err, exp_bad); end
        byte_en = 4'b0001; #1;
        checks++; if (par_err !== 1'b0)    begin errors++; $display("FAIL par_lane0: got %b expected 0", par_err); end
        byte_en = 4'b1111; #1;
        checks++; if (par_err !== exp_bad) begin errors++; $display("FAIL par_all: got %b expected %b", par_err, exp_bad); end
        pen = 1'b0; #1;
        checks++; if (par_err !== 1'b0)    begin errors++; $display("FAIL par_pen0: got %b expected 0", par_err); end
        pen = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        checks++; if (par_err !== 1'b0)    begin errors++; $display("FAIL par_empty: got %b expected 0", par_err); end
        pen = 1'b0; byte_en = 4'b0000;
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 40; w++) begin
            logic [1:0]  bw;
            logic [31:0] word;
            int          nb;
            int          i;
            bw   = 2'($urandom_range(0, 2));
            word = $urandom;
            nb   = (bw == 2'b00) ? 4 : (bw == 2'b01) ? 2 : 1;
            bus_width = bw;
            i = 0;
            while (i < nb) begin
                logic idle;
                logic r;
                idle = ($urandom_range(0, 3) == 0);
                r    = 1'($urandom_range(0, 1));
                if (idle) begin
                    cycle(1'b0, '0, r, 1'b0, 1'b0, '0);
                end else begin
                    cycle(1'b1, make_beat(bw, word, i), r, 1'b0, i == nb - 1, word);
                    i++;
                end
                checks++; if (cnt !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", cnt, exp_q.size()); end
                checks++; if (ovf !== exp_ovf)          begin errors++; $display("FAIL b2b_ovf: got %b expected %b", ovf, exp_ovf); end
                if (exp_q.size() > 0) begin
                    checks++; if (dout !== exp_q[0]) begin errors++; $display("FAIL b2b_dout: got %h expected %h", dout, exp_q[0]); end
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
            checks++; if (cnt !== 3'(exp_q.size())) begin errors++; $display("FAIL drain_cnt: got %0d expected %0d", cnt, exp_q.size()); end
            if (exp_q.size() > 0) begin
                checks++; if (dout !== exp_q[0]) begin errors++; $display("FAIL drain_dout: got %h expected %h", dout, exp_q[0]); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) send_word(2'b10, 32'hC000_0000 + 32'(i));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL pre_arst_cnt: got %0d expected 3", cnt); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pre_arst_ovf: got %b expected 1", ovf); end
        // assert reset between clock edges and look before the next edge
        #2 rst = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b expected 1", empty); end
        checks++; if (cnt !== 3'd0)   begin errors++; $display("FAIL arst_cnt: got %0d expected 0", cnt); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL arst_ovf: got %b expected 0", ovf); end
        checks++; if (full !== 1'b0)  begin errors++; $display("FAIL arst_full: got %b expected 0", full); end
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        // reset in the middle of a word restarts packing at lane 0
        bus_width = 2'b00;
        cycle(1'b1, 36'h0_0000_0077, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 36'h0_0000_0066, 1'b0, 1'b0, 1'b0, '0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        send_word(2'b00, 32'hCAFE_F00D);
        checks++; if (dout !== 32'hCAFEF00D) begin errors++; $display("FAIL midword_rst_dout: got %h expected cafef00d", dout); end
        checks++; if (cnt !== 3'd1)          begin errors++; $display("FAIL midword_rst_cnt: got %0d expected 1", cnt); end
    endtask

    initial begin
        rst         = 1'b0;
        clr         = 1'b0;
        bus_width   = 2'b00;
        pen         = 1'b0;
        dv          = 1'b0;
        mc_data_del = '0;
        re          = 1'b0;
        byte_en     = 4'b0000;
        test_reset();
        test_pack8();
        test_pack16();
        test_overflow();
        test_clr();
        test_parity();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_dp_pack.md
MC_DP_PACK -- requirements
Module: mc_dp_pack

Interface
REQ-001 SHALL have parameter DW, default 32, read data width in bits (multiple of 16, >=16).
REQ-002 SHALL have parameter DEPTH, default 4, read FIFO depth in words (power of 2, >=2).
REQ-003 SHALL have parameter AW, default 2, equal to log2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 clr  in  1  synchronous flush of packer and FIFO.
REQ-007 bus_width  in  2  00=8-bit, 01=16-bit, 10/11=full DW-bit memory bus.
REQ-008 pen  in  1  parity check enable.
REQ-009 dv  in  1  beat valid on mc_data_del.
REQ-010 mc_data_del  in  DW+DW/8  beat: data [DW-1:0], per-byte parity [DW+DW/8-1:DW]; narrow beats in low lanes.
REQ-011 re  in  1  pop FIFO head.
REQ-012 byte_en  in  DW/8  active-high byte lanes checked for parity.
REQ-013 dout  out  DW  FIFO head data, combinational from storage.
REQ-014 empty, full  out  1 each  FIFO status.
REQ-015 cnt  out  AW+1  FIFO occupancy, 0..DEPTH.
REQ-016 ovf  out  1  sticky overflow flag.
REQ-017 par_err  out  1  parity error on FIFO head.

Function
REQ-018 Packer SHALL assemble DW/8 beats (8-bit), DW/16 beats (16-bit) or 1 beat (full) into one word, first beat in lowest lane; parity bits follow their byte.
REQ-019 Beat-lane counter SHALL advance only on dv and wrap to 0 on the word-completing beat.
REQ-020 Completing beat SHALL write the assembled word (completing beat taken directly, not via register) into FIFO at the same edge; latency dv-to-!empty is 1 cycle.
REQ-021 A bus_width change SHALL take effect from the next word; caller changes it only with lane counter at 0 or together with clr.
REQ-022 FIFO SHALL be first-word-fall-through; dout valid whenever !empty; dout undefined-but-stable when empty.
REQ-023 re while empty SHALL be ignored; pointers and cnt unchanged.
REQ-024 Push while full without simultaneous pop SHALL drop the word and set ovf; ovf stays set until clr or reset.
REQ-025 Push and pop in same cycle SHALL both occur, including when full (cnt unchanged) and when empty with push only effective (pop ignored).
REQ-026 Pointers SHALL wrap modulo DEPTH; full = (cnt==DEPTH), empty = (cnt==0).
REQ-027 par_err SHALL equal pen & !empty & OR over lanes i of byte_en[i] & (XOR(byte i) ^ pbit i) (even parity), combinational.
REQ-028 clr SHALL, at the edge, zero pointers, cnt, lane counter, ovf; clr has priority over dv and re in that cycle.

Reset
REQ-029 On rst low SHALL asynchronously force pointers=0, cnt=0, lane counter=0, ovf=0; hence empty=1, full=0, par_err=0.
REQ-030 FIFO storage and pack byte registers SHALL NOT be reset.
REQ-031 Reset deasserted mid-word SHALL restart packing at lane 0.

Configuration
REQ-032 With MC_DP_PARITY_EN defined, FIFO SHALL store DW+DW/8 bits per entry and par_err follows REQ-027.
REQ-033 Without MC_DP_PARITY_EN, FIFO SHALL store DW bits only, parity inputs ignored, par_err tied 0.

Verification
REQ-034 DW=32, bus_width=00, beats 0x11,0x22,0x33,0x44 on 4 dv cycles -> next cycle empty=0, dout=0x44332211, cnt=1.
REQ-035 bus_width=01, beats 0xBEEF,0xDEAD -> dout=0xDEADBEEF; re one cycle -> empty=1, cnt=0.
REQ-036 DEPTH=4, full mode, 5 pushes no pops -> full=1, cnt=4, ovf=1, dout=first word; then push+pop same cycle -> cnt=4, 2nd word at head.
REQ-037 MC_DP_PARITY_EN, pen=1, byte_en=4'b0010, word 0x000001_00 with pbit1=0 -> par_err=1; byte_en=4'b0001 -> par_err=0; pen=0 -> par_err=0.
REQ-038 Two beats into 8-bit word then clr -> lane counter 0, empty=1, ovf=0; following 4 beats form a correct word.
REQ-039 rst low asserted asynchronously with cnt=3, ovf=1 -> immediately empty=1, cnt=0, ovf=0 without clock edge.
